// File: rtl/la_rle_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : la_rle_capture
// Purpose  : Logic-analyzer capture core. Masked trigger, run-length encoding
//            into {count, sample} words, FWFT buffer FIFO, packetised AXIS out.
// Revision : 1.0
// ============================================================================
module la_rle_capture #(
    parameter int pSAMPLE_WIDTH = 24,
    parameter int pCOUNT_WIDTH  = 8,
    parameter int pFIFO_AW      = 6
) (
    input  logic                                  axi_clk,
    input  logic                                  axi_reset,
    input  logic                                  cfg_enable,
    input  logic [pSAMPLE_WIDTH-1:0]              cfg_trig_mask,
    input  logic [pSAMPLE_WIDTH-1:0]              cfg_trig_value,
    input  logic [pFIFO_AW:0]                     cfg_h_thresh,
    input  logic [pFIFO_AW:0]                     cfg_l_thresh,
    input  logic [7:0]                            cfg_pkt_len,
    input  logic [pSAMPLE_WIDTH-1:0]              up_la_data,
    output logic [pCOUNT_WIDTH+pSAMPLE_WIDTH-1:0] m_tdata,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic                                  m_tlast,
    output logic [1:0]                            m_tuser,
    output logic                                  la_hpri_req,
    output logic [pFIFO_AW:0]                     fifo_level,
    output logic [15:0]                           overflow_cnt,
    output logic                                  busy
);

    localparam int c_WORD_W = pCOUNT_WIDTH + pSAMPLE_WIDTH;
    localparam int c_ENT_W  = c_WORD_W + 3;
    localparam int c_DEPTH  = 1 << pFIFO_AW;
    localparam logic [pFIFO_AW:0]     c_PTR_ONE = 1;
    localparam logic [pCOUNT_WIDTH-1:0] c_CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t                    state_q;
    logic [pSAMPLE_WIDTH-1:0]  cur_q;
    logic [pCOUNT_WIDTH-1:0]   cnt_q;
    logic                      first_q;
    logic                      gap_q, gap_d;
    logic                      hpri_q;
    logic [15:0]               ovf_q, ovf_d;
    logic [7:0]                beat_q, beat_d;
    logic [pFIFO_AW:0]         wr_ptr_q, rd_ptr_q;
    logic [c_ENT_W-1:0]        mem_q [c_DEPTH];

    logic [pFIFO_AW:0]         w_level;
    logic                      w_empty, w_full, w_pop;
    logic                      w_run_brk, w_push_req, w_accept, w_drop;
    logic [c_ENT_W-1:0]        w_push_ent, w_rd_ent;

    // Pointers carry an extra MSB so level is exact at both full and empty.
    assign w_level    = wr_ptr_q - rd_ptr_q;
    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = w_level[pFIFO_AW];
    assign w_pop      = !w_empty && m_tready;

    assign w_run_brk  = (up_la_data != cur_q) || (cnt_q == {pCOUNT_WIDTH{1'b1}});
    assign w_push_req = ((state_q == ST_CAPTURE) && cfg_enable && w_run_brk)
                        || (state_q == ST_FLUSH);
    assign w_accept   = w_push_req && (!w_full || w_pop);
    // The flush word is never dropped; it simply waits for room.
    assign w_drop     = w_push_req && !w_accept && (state_q == ST_CAPTURE);

    // Entry layout: {last, gap, first, count, sample}
    assign w_push_ent = {(state_q == ST_FLUSH), gap_q, first_q, cnt_q, cur_q};
    assign w_rd_ent   = w_empty ? '0 : mem_q[rd_ptr_q[pFIFO_AW-1:0]];

    assign m_tdata      = w_rd_ent[c_WORD_W-1:0];
    assign m_tuser      = w_rd_ent[c_WORD_W+1:c_WORD_W];
    assign m_tvalid     = !w_empty;
    assign m_tlast      = !w_empty && (w_rd_ent[c_WORD_W+2] || (beat_q == cfg_pkt_len - 8'd1));
    assign la_hpri_req  = hpri_q;
    assign fifo_level   = w_level;
    assign overflow_cnt = ovf_q;
    assign busy         = (state_q != ST_IDLE);

    always_comb begin
        beat_d = beat_q;
        gap_d  = gap_q;
        ovf_d  = ovf_q;
        if (w_pop) begin
            beat_d = m_tlast ? 8'd0 : beat_q + 8'd1;
        end
        if (w_accept) begin
            gap_d = 1'b0;
        end else if (w_drop) begin
            gap_d = 1'b1;
            if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q[pFIFO_AW-1:0]] <= w_push_ent;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            gap_q    <= 1'b0;
            hpri_q   <= 1'b0;
            ovf_q    <= '0;
            beat_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!cfg_enable) begin
                        state_q <= ST_IDLE;
                    end else if (((up_la_data ^ cfg_trig_value) & cfg_trig_mask) == '0) begin
                        state_q <= ST_CAPTURE;
                        cur_q   <= up_la_data;
                        cnt_q   <= c_CNT_ONE;
                        first_q <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (!cfg_enable) begin
                        state_q <= ST_FLUSH;
                    end else if (w_run_brk) begin
                        cur_q   <= up_la_data;
                        cnt_q   <= c_CNT_ONE;
                        first_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (w_accept) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (w_accept) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            beat_q <= beat_d;
            gap_q  <= gap_d;
            ovf_q  <= ovf_d;

            // Set wins over clear when the thresholds overlap.
            if (w_level >= cfg_h_thresh) begin
                hpri_q <= 1'b1;
            end else if (w_level <= cfg_l_thresh) begin
                hpri_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_rle_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_la_rle_capture
// Purpose  : Self-checking bench for la_rle_capture (table, directed, random).
// Revision : 1.0
// ============================================================================
module tb_la_rle_capture;

    localparam int SW = 24;
    localparam int CW = 8;
    localparam int AW = 6;

    typedef logic [34:0] beat_t;   // {tlast, tuser[1], tuser[0], count, sample}

    typedef struct {
        logic [23:0] data;
        int          len;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } run_vec_t;

    logic           axi_clk = 1'b0;
    logic           axi_reset = 1'b1;
    logic           cfg_enable = 1'b0;
    logic [SW-1:0]  cfg_trig_mask = '0;
    logic [SW-1:0]  cfg_trig_value = '0;
    logic [AW:0]    cfg_h_thresh = 7'd48;
    logic [AW:0]    cfg_l_thresh = 7'd16;
    logic [7:0]     cfg_pkt_len = 8'd0;
    logic [SW-1:0]  up_la_data = '0;
    logic [CW+SW-1:0] m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b1;
    logic           m_tlast;
    logic [1:0]     m_tuser;
    logic           la_hpri_req;
    logic [AW:0]    fifo_level;
    logic [15:0]    overflow_cnt;
    logic           busy;

    int checks = 0;
    int failures = 0;

    beat_t       rx_q[$];
    beat_t       exp_q[$];
    logic        log_en[$];
    logic [23:0] log_d[$];
    logic        log_on = 1'b0;
    logic        mon_on = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        exp_hpri = 1'b0;
    logic        prev_hold = 1'b0;
    logic [33:0] prev_word = '0;
    run_vec_t    tbl[6];

    la_rle_capture #(
        .pSAMPLE_WIDTH(SW),
        .pCOUNT_WIDTH (CW),
        .pFIFO_AW     (AW)
    ) dut (
        .axi_clk       (axi_clk),
        .axi_reset     (axi_reset),
        .cfg_enable    (cfg_enable),
        .cfg_trig_mask (cfg_trig_mask),
        .cfg_trig_value(cfg_trig_value),
        .cfg_h_thresh  (cfg_h_thresh),
        .cfg_l_thresh  (cfg_l_thresh),
        .cfg_pkt_len   (cfg_pkt_len),
        .up_la_data    (up_la_data),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .la_hpri_req   (la_hpri_req),
        .fifo_level    (fifo_level),
        .overflow_cnt  (overflow_cnt),
        .busy          (busy)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; the negedge then sees what the next edge sees.
    initial forever begin
        @(negedge axi_clk);
        if (!axi_reset && m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tuser, m_tdata});
        if (mon_on) begin
            chk("hpri_req", la_hpri_req, exp_hpri);
            if (prev_hold) begin
                chk("stall tvalid", m_tvalid, 1'b1);
                chk("stall tdata/tuser", {m_tuser, m_tdata}, prev_word);
            end
        end
        prev_hold = !axi_reset && m_tvalid && !m_tready;
        prev_word = {m_tuser, m_tdata};
    end

    initial forever begin
        @(posedge axi_clk);
        if (axi_reset)                       exp_hpri = 1'b0;
        else if (fifo_level >= cfg_h_thresh) exp_hpri = 1'b1;
        else if (fifo_level <= cfg_l_thresh) exp_hpri = 1'b0;
        if (log_on) begin
            log_en.push_back(cfg_enable);
            log_d.push_back(up_la_data);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic en, input logic [23:0] d);
        cfg_enable = en;
        up_la_data = d;
        if (rnd_ready) m_tready = ($urandom_range(0, 3) != 0);
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        axi_reset  = 1'b1;
        cfg_enable = 1'b0;
        m_tready   = 1'b1;
        repeat (2) @(posedge axi_clk);
        #1;
        axi_reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        log_en.delete();
        log_d.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((busy || m_tvalid) && n < 2000) begin
            step(cfg_enable, up_la_data);
            n++;
        end
        chk({name, " drain {busy,tvalid}"}, {busy, m_tvalid}, 2'b00);
    endtask

    // Reference: arm on first enabled edge, trigger on a later masked match,
    // collect samples until enable drops, then split runs into <=255 chunks.
    task automatic build_expected(input logic [23:0] mask, input logic [23:0] value, input int plen);
        logic [23:0] smp[$];
        beat_t       w[$];
        int          i, n, p, k, len, c, r;
        logic        last;
        i = 0;
        n = log_en.size();
        p = (plen == 0) ? 256 : plen;
        while (i < n && !log_en[i]) i++;
        i++;
        while (i < n && log_en[i] && (((log_d[i] ^ value) & mask) != 24'd0)) i++;
        while (i < n && log_en[i]) begin
            smp.push_back(log_d[i]);
            i++;
        end
        k = 0;
        while (k < smp.size()) begin
            len = 1;
            while (k + len < smp.size() && smp[k + len] == smp[k]) len++;
            for (r = len; r > 0; r -= 255) begin
                c = (r > 255) ? 255 : r;
                w.push_back({3'b000, 8'(c), smp[k]});
            end
            k += len;
        end
        for (int j = 0; j < w.size(); j++) begin
            last = ((j % p) == p - 1) || (j == w.size() - 1);
            exp_q.push_back({last, 1'b0, (j == 0), w[j][31:0]});
        end
        log_en.delete();
        log_d.delete();
    endtask

    task automatic cmp_stream(input string name);
        chk({name, " word count"}, rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
            chk($sformatf("%s word%0d", name, k), rx_q[k], exp_q[k]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          rem, len, n;
        logic [23:0] d;

        tbl[0] = '{24'hABCDEF, 300, 2, 32'hFFABCDEF, 32'h2DABCDEF};
        tbl[1] = '{24'h000001,   5, 1, 32'h05000001, 32'h0};
        tbl[2] = '{24'h123456, 255, 1, 32'hFF123456, 32'h0};
        tbl[3] = '{24'h123457, 256, 2, 32'hFF123457, 32'h01123457};
        tbl[4] = '{24'h000000,   1, 1, 32'h01000000, 32'h0};
        tbl[5] = '{24'hFFFFFF, 510, 2, 32'hFFFFFFFF, 32'hFFFFFFFF};

        do_reset();
        chk("reset tvalid", m_tvalid, 1'b0);
        chk("reset tlast", m_tlast, 1'b0);
        chk("reset tuser", m_tuser, 2'b00);
        chk("reset tdata", m_tdata, 32'h0);
        chk("reset hpri", la_hpri_req, 1'b0);
        chk("reset level", fifo_level, 7'd0);
        chk("reset overflow", overflow_cnt, 16'd0);
        chk("reset busy", busy, 1'b0);
        mon_on = 1'b1;

        // Ramp of single-cycle runs, 16-beat packets
        cfg_pkt_len = 8'd16;
        log_on = 1'b1;
        step(1'b1, 24'd0);
        for (int i = 0; i < 200; i++) step(1'b1, 24'(i));
        step(1'b0, 24'd0);
        log_on = 1'b0;
        wait_drain("ramp");
        build_expected(24'd0, 24'd0, 16);
        chk("ramp first word", (rx_q.size() > 0) ? rx_q[0] : beat_t'(0), {1'b0, 2'b01, 32'h01000000});
        chk("ramp last word", (rx_q.size() > 199) ? rx_q[199] : beat_t'(0), {1'b1, 2'b00, 32'h010000C7});
        cmp_stream("ramp");

        // Run-length table, pkt_len 0 means 256
        do_reset();
        cfg_pkt_len = 8'd0;
        step(1'b1, tbl[0].data);
        for (int i = 0; i < 6; i++) begin
            repeat (tbl[i].len) step(1'b1, tbl[i].data);
            for (int j = 0; j < tbl[i].nw; j++)
                exp_q.push_back({3'b000, (j == 0) ? tbl[i].w0 : tbl[i].w1});
        end
        exp_q[0][32] = 1'b1;
        exp_q[exp_q.size() - 1][34] = 1'b1;
        step(1'b0, 24'd0);
        wait_drain("table");
        cmp_stream("table");

        // Masked trigger
        do_reset();
        cfg_pkt_len    = 8'd16;
        cfg_trig_mask  = 24'h0000FF;
        cfg_trig_value = 24'h000005;
        log_on = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 24'(i));
        step(1'b1, 24'd9);
        step(1'b0, 24'd0);
        log_on = 1'b0;
        wait_drain("trigger");
        build_expected(24'h0000FF, 24'h000005, 16);
        chk("trigger first word", (rx_q.size() > 0) ? rx_q[0] : beat_t'(0), {1'b0, 2'b01, 32'h01000005});
        cmp_stream("trigger");

        // Randomised captures with random back-pressure
        for (int t = 0; t < 4; t++) begin
            do_reset();
            cfg_trig_mask  = 24'($urandom_range(0, 3));
            cfg_trig_value = 24'($urandom_range(0, 7));
            cfg_pkt_len    = 8'($urandom_range(0, 6));
            rnd_ready = 1'b1;
            log_on    = 1'b1;
            step(1'b0, 24'($urandom_range(0, 7)));
            step(1'b0, 24'($urandom_range(0, 7)));
            rem = 150;
            while (rem > 0) begin
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 260)) : int'($urandom_range(1, 6));
                d   = 24'($urandom_range(0, 7));
                repeat (len) step(1'b1, d);
                rem -= len;
            end
            step(1'b0, 24'd0);
            log_on = 1'b0;
            wait_drain("random");
            build_expected(cfg_trig_mask, cfg_trig_value, int'(cfg_pkt_len));
            chk("random overflow", overflow_cnt, 16'd0);
            cmp_stream($sformatf("random%0d", t));
            rnd_ready = 1'b0;
            m_tready  = 1'b1;
        end
        cfg_trig_mask  = 24'd0;
        cfg_trig_value = 24'd0;

        // Overflow and hysteresis
        do_reset();
        cfg_pkt_len = 8'd0;
        m_tready    = 1'b0;
        step(1'b1, 24'h100);
        for (int i = 0; i < 100; i++) step(1'b1, 24'h100 + 24'(i));
        chk("ovf level full", fifo_level, 7'd64);
        chk("ovf count 35..36", (overflow_cnt == 16'd35) || (overflow_cnt == 16'd36), 1'b1);
        chk("ovf hpri set", la_hpri_req, 1'b1);
        m_tready = 1'b1;
        n = 0;
        while (fifo_level != 7'd0 && n < 200) begin
            step(1'b1, 24'h163);
            n++;
        end
        chk("ovf hpri cleared", la_hpri_req, 1'b0);
        step(1'b0, 24'd0);
        wait_drain("overflow");
        chk("ovf rx count", rx_q.size(), 65);
        for (int k = 0; k < 64 && k < rx_q.size(); k++)
            chk($sformatf("ovf word%0d", k), rx_q[k], {1'b0, 1'b0, (k == 0), 8'h01, 24'h100 + 24'(k)});
        if (rx_q.size() > 64) begin
            chk("ovf gap word flags", {rx_q[64][34:32], rx_q[64][23:0]}, {3'b110, 24'h163});
            chk("ovf gap word nonzero count", rx_q[64][31:24] != 8'd0, 1'b1);
        end
        rx_q.delete();

        // Flush while full
        do_reset();
        m_tready = 1'b0;
        step(1'b1, 24'h200);
        for (int i = 0; i < 70; i++) step(1'b1, 24'h200 + 24'(i));
        step(1'b0, 24'd0);
        repeat (10) step(1'b0, 24'd0);
        chk("flush busy held", busy, 1'b1);
        chk("flush level", fifo_level, 7'd64);
        m_tready = 1'b1;
        wait_drain("flush");
        chk("flush rx count", rx_q.size(), 65);
        if (rx_q.size() > 64) begin
            chk("flush word63", rx_q[63], {3'b000, 8'h01, 24'h23F});
            chk("flush final word", rx_q[64], {3'b110, 8'h01, 24'h245});
        end
        rx_q.delete();

        // Reset mid-capture
        do_reset();
        m_tready = 1'b0;
        step(1'b1, 24'h300);
        for (int i = 0; i < 80; i++) step(1'b1, 24'h300 + 24'(i));
        chk("pre-reset overflow", overflow_cnt, 16'd15);
        chk("pre-reset hpri", la_hpri_req, 1'b1);
        axi_reset  = 1'b1;
        cfg_enable = 1'b0;
        @(posedge axi_clk);
        #1;
        axi_reset = 1'b0;
        chk("post-reset tvalid", m_tvalid, 1'b0);
        chk("post-reset level", fifo_level, 7'd0);
        chk("post-reset overflow", overflow_cnt, 16'd0);
        chk("post-reset hpri", la_hpri_req, 1'b0);
        chk("post-reset busy", busy, 1'b0);
        rx_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
